pc_fetch_unit: RTL and testbench

//  Parametrised next-generation program counter. Drives the fetch address into instruction memory with a

---
 rtl/pc_fetch_unit.sv | 112 +++++++++++
 tb/tb_pc_fetch_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter / fetch address generator with valid/ready handshake, flush redirects and halt control.
// Optional macro PC_RVC_EN enables compressed (16-bit) instruction support: 2-byte increment and alignment.
module pc_fetch_unit #(
    parameter int                   PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = PC_WIDTH'(32'h0000_0010)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_ready,
    input  logic                redirect_valid,
    input  logic                redirect_jalr,
    input  logic [PC_WIDTH-1:0] redirect_base,
    input  logic [PC_WIDTH-1:0] redirect_offset,
    input  logic                halt_req,
    input  logic                resume,
    input  logic                instr_is_c,
    output logic [PC_WIDTH-1:0] pc,
    output logic                pc_valid,
    output logic [PC_WIDTH-1:0] pc_link,
    output logic                halted,
    output logic                misalign_err
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] inc;
    logic [PC_WIDTH-1:0] raw_target;
    logic [PC_WIDTH-1:0] target;
    logic                misaligned;
    logic                advance;

`ifdef PC_RVC_EN
    assign inc = instr_is_c ? PC_WIDTH'(2) : PC_WIDTH'(4);
`else
    // Compressed instructions are not supported in this build; the input is deliberately ignored.
    logic unused_instr_is_c;
    assign unused_instr_is_c = instr_is_c;
    assign inc               = PC_WIDTH'(4);
`endif

    assign pc_link = pc + inc;

    always_comb begin
        raw_target = redirect_base + redirect_offset;
        target     = raw_target;
        if (redirect_jalr) begin
            target[0] = 1'b0;
        end
`ifdef PC_RVC_EN
        misaligned = target[0];
`else
        misaligned = |target[1:0];
`endif
    end

    // A halt request takes priority over advancing, so the pc is held for the resume fetch.
    assign advance = (state == RUN) && pc_valid && pc_ready && !redirect_valid && !halt_req;

    // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            pc_valid     <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;

            unique case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                    halted   <= 1'b0;
                end
                RUN: begin
                    if (halt_req) begin
                        state    <= HALTED;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end
                end
                HALTED: begin
                    if (resume && !halt_req) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase

            if (redirect_valid) begin
                pc           <= misaligned ? TRAP_VECTOR : target;
                misalign_err <= misaligned;
            end else if (advance) begin
                pc <= pc + inc;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; expected values are hand-computed constants.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        pc_ready;
    logic        redirect_valid;
    logic        redirect_jalr;
    logic [31:0] redirect_base;
    logic [31:0] redirect_offset;
    logic        halt_req;
    logic        resume;
    logic        instr_is_c;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] pc_link;
    logic        halted;
    logic        misalign_err;

    int vectors    = 0;
    int miscompares = 0;

    pc_fetch_unit #(
        .PC_WIDTH    (32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0010)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_ready       (pc_ready),
        .redirect_valid (redirect_valid),
        .redirect_jalr  (redirect_jalr),
        .redirect_base  (redirect_base),
        .redirect_offset(redirect_offset),
        .halt_req       (halt_req),
        .resume         (resume),
        .instr_is_c     (instr_is_c),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .pc_link        (pc_link),
        .halted         (halted),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1ns later, inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] exp_pc,
                                input logic exp_valid, input logic exp_halted, input logic exp_err);
        check({tag, ".pc"},       pc,                  exp_pc);
        check({tag, ".valid"},    {31'd0, pc_valid},   {31'd0, exp_valid});
        check({tag, ".halted"},   {31'd0, halted},     {31'd0, exp_halted});
        check({tag, ".misalign"}, {31'd0, misalign_err}, {31'd0, exp_err});
    endtask

    task automatic redirect(input logic jalr, input logic [31:0] base, input logic [31:0] off);
        redirect_valid  = 1'b1;
        redirect_jalr   = jalr;
        redirect_base   = base;
        redirect_offset = off;
        step();
        redirect_valid  = 1'b0;
        redirect_jalr   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc_ready = 1'b1; redirect_valid = 1'b0; redirect_jalr = 1'b0;
        redirect_base = '0; redirect_offset = '0; halt_req = 1'b0; resume = 1'b0; instr_is_c = 1'b0;

        // Reset and boot, then full-rate fetch.
        step(); step();
        expect_state("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        expect_state("boot_exit", 32'h0, 1'b1, 1'b0, 1'b0);
        check("link_at_0", pc_link, 32'h4);
        step(); check("run_pc4", pc, 32'h4);
        step(); check("run_pc8", pc, 32'h8);

        // Stall holds the request stable.
        pc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'h8);
            check("stall_valid", {31'd0, pc_valid}, 32'd1);
        end
        pc_ready = 1'b1;
        step(); check("stall_release", pc, 32'hC);

        // Redirect under stall, backward branch and JALR bit-0 clear.
        redirect(1'b0, 32'h20, 32'h0);
        check("redir_0x20", pc, 32'h20);
        pc_ready = 1'b0;
        redirect(1'b0, 32'h20, 32'hFFFF_FFF0);
        expect_state("redir_back", 32'h10, 1'b1, 1'b0, 1'b0);
        check("link_at_10", pc_link, 32'h14);
        redirect(1'b1, 32'h101, 32'h0);
        expect_state("jalr", 32'h100, 1'b1, 1'b0, 1'b0);

        // 2-byte aligned target.
        redirect(1'b0, 32'h100, 32'h2);
`ifdef PC_RVC_EN
        expect_state("rvc_target", 32'h102, 1'b1, 1'b0, 1'b0);
        instr_is_c = 1'b1;
        check("rvc_link", pc_link, 32'h104);
        pc_ready = 1'b1;
        step();
        check("rvc_adv", pc, 32'h104);
        instr_is_c = 1'b0;
        pc_ready = 1'b0;
`else
        expect_state("trap", 32'h10, 1'b1, 1'b0, 1'b1);
        step();
        expect_state("trap_pulse_end", 32'h10, 1'b1, 1'b0, 1'b0);
`endif
        // Odd non-JALR target traps in every build.
        redirect(1'b0, 32'h101, 32'h0);
        expect_state("odd_trap", 32'h10, 1'b1, 1'b0, 1'b1);

        // Halt and resume.
        pc_ready = 1'b1;
        redirect(1'b0, 32'h40, 32'h0);
        check("pre_halt", pc, 32'h40);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        expect_state("halt", 32'h40, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("halt_hold_pc", pc, 32'h40);
            check("halt_hold_flag", {31'd0, halted}, 32'd1);
        end
        resume = 1'b1; halt_req = 1'b1;
        step();
        expect_state("resume_vs_halt", 32'h40, 1'b0, 1'b1, 1'b0);
        halt_req = 1'b0;
        step();
        resume = 1'b0;
        expect_state("resume", 32'h40, 1'b1, 1'b0, 1'b0);
        step(); check("resume_adv", pc, 32'h44);

        // Redirect together with halt: new pc and halted.
        halt_req = 1'b1;
        redirect(1'b0, 32'h80, 32'h0);
        halt_req = 1'b0;
        expect_state("redir_halt", 32'h80, 1'b0, 1'b1, 1'b0);
        redirect(1'b0, 32'h90, 32'h0);
        expect_state("redir_in_halt", 32'h90, 1'b0, 1'b1, 1'b0);
        resume = 1'b1;
        step();
        resume = 1'b0;
        expect_state("resume2", 32'h90, 1'b1, 1'b0, 1'b0);

        // Wrap at the top of the address space.
        redirect(1'b0, 32'hFFFF_FFF0, 32'hC);
        check("top_pc", pc, 32'hFFFF_FFFC);
        check("top_link", pc_link, 32'h0);
        step(); check("wrap", pc, 32'h0);

        // Reset while halted with a redirect pending wins.
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt_again", {31'd0, halted}, 32'd1);
        rst = 1'b1;
        redirect(1'b0, 32'h200, 32'h0);
        expect_state("rst_over_redir", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        expect_state("reboot", 32'h0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
